// File: rtl/imm_pkg.sv
// Shared encodings and field positions for the immediate extender.
package imm_pkg;

  localparam logic [3:0] IMM_CTRL_LDST  = 4'd0;
  localparam logic [3:0] IMM_CTRL_ADDI  = 4'd1;
  localparam logic [3:0] IMM_CTRL_CBZ   = 4'd2;
  localparam logic [3:0] IMM_CTRL_B     = 4'd3;
  localparam logic [3:0] IMM_CTRL_MOVZ  = 4'd4;
  localparam logic [3:0] IMM_CTRL_MOVK  = 4'd5;
  localparam logic [3:0] IMM_CTRL_ADDIS = 4'd6;
  localparam logic [3:0] IMM_CTRL_MOVN  = 4'd7;

  localparam int unsigned D_LSB   = 12;
  localparam int unsigned D_MSB   = 20;
  localparam int unsigned I_LSB   = 10;
  localparam int unsigned I_MSB   = 21;
  localparam int unsigned CB_LSB  = 5;
  localparam int unsigned CB_MSB  = 23;
  localparam int unsigned MOV_LSB = 5;
  localparam int unsigned MOV_MSB = 20;
  localparam int unsigned HW_LSB  = 21;
  localparam int unsigned HW_MSB  = 22;
  localparam int unsigned ISH_BIT = 22;

  // A halfword position is usable only if it lies entirely inside the datapath.
  function automatic logic hw_shift_legal(input logic [1:0] hw, input int unsigned data_w);
    return ((32'(hw) << 4) < data_w);
  endfunction

endpackage

// File: rtl/imm_decode.sv
// Combinational immediate decoder: format select plus accumulator read to result.
module imm_decode
  import imm_pkg::*;
#(
  parameter int unsigned DATA_W = 64
) (
  input  logic [25:0]       imm_i,
  input  logic [3:0]        ctrl_i,
  input  logic [DATA_W-1:0] acc_rd_i,
  output logic [DATA_W-1:0] imm_o,
  output logic              err_o,
  output logic              acc_we_o
);

  logic [1:0]        hw;
  logic [5:0]        hw_sh;
  logic              hw_ok;
  logic [DATA_W-1:0] mov_val;
  logic [DATA_W-1:0] hw_mask;
  logic [DATA_W-1:0] add_val;

  assign hw      = imm_i[HW_MSB:HW_LSB];
  assign hw_sh   = {hw, 4'b0000};
  assign hw_ok   = hw_shift_legal(hw, DATA_W);
  assign mov_val = DATA_W'(imm_i[MOV_MSB:MOV_LSB]) << hw_sh;
  assign hw_mask = DATA_W'(16'hFFFF) << hw_sh;
  assign add_val = DATA_W'(imm_i[I_MSB:I_LSB]);

  always_comb begin
    imm_o    = '0;
    err_o    = 1'b0;
    acc_we_o = 1'b0;
    case (ctrl_i)
      IMM_CTRL_LDST:  imm_o = DATA_W'($signed(imm_i[D_MSB:D_LSB]));
      IMM_CTRL_ADDI:  imm_o = add_val;
      IMM_CTRL_CBZ:   imm_o = DATA_W'($signed({imm_i[CB_MSB:CB_LSB], 2'b00}));
      IMM_CTRL_B:     imm_o = DATA_W'($signed({imm_i, 2'b00}));
      IMM_CTRL_ADDIS: imm_o = imm_i[ISH_BIT] ? (add_val << 12) : add_val;
      IMM_CTRL_MOVZ, IMM_CTRL_MOVK, IMM_CTRL_MOVN: begin
        if (hw_ok) begin
          acc_we_o = 1'b1;
          if (ctrl_i == IMM_CTRL_MOVZ) begin
            imm_o = mov_val;
          end else if (ctrl_i == IMM_CTRL_MOVK) begin
            imm_o = (acc_rd_i & ~hw_mask) | mov_val;
          end else begin
            imm_o = ~mov_val;
          end
        end else begin
          err_o = 1'b1;
        end
      end
      default: begin
        imm_o = DATA_W'(imm_i);
        err_o = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/imm_extend_pipe.sv
// Pipelined immediate extender: wide-move accumulators, output register and one skid entry.
module imm_extend_pipe
  import imm_pkg::*;
#(
  parameter int unsigned DATA_W    = 64,
  parameter int unsigned ACC_SLOTS = 4,
  localparam int unsigned SEL_W    = $clog2(ACC_SLOTS)
) (
  input  logic              CLK,
  input  logic              resetl,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [25:0]       in_imm,
  input  logic [3:0]        in_ctrl,
  input  logic [SEL_W-1:0]  in_acc_sel,
  input  logic              acc_clr,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_imm,
  output logic              out_err
);

  logic [DATA_W-1:0] acc_q [ACC_SLOTS];
  logic [DATA_W-1:0] acc_d [ACC_SLOTS];
  logic [DATA_W-1:0] acc_rd;
  logic [DATA_W-1:0] dec_imm;
  logic              dec_err;
  logic              dec_we;
  logic              accept;

  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] out_imm_q, out_imm_d;
  logic              out_err_q, out_err_d;
  logic              skid_valid_q, skid_valid_d;
  logic [DATA_W-1:0] skid_imm_q, skid_imm_d;
  logic              skid_err_q, skid_err_d;

  // A coincident clear is visible to the op being accepted.
  assign acc_rd = acc_clr ? '0 : acc_q[in_acc_sel];

  imm_decode #(
    .DATA_W(DATA_W)
  ) u_decode (
    .imm_i   (in_imm),
    .ctrl_i  (in_ctrl),
    .acc_rd_i(acc_rd),
    .imm_o   (dec_imm),
    .err_o   (dec_err),
    .acc_we_o(dec_we)
  );

  assign in_ready  = ~skid_valid_q;
  assign accept    = in_valid & in_ready;
  assign out_valid = out_valid_q;
  assign out_imm   = out_imm_q;
  assign out_err   = out_err_q;

  always_comb begin
    for (int i = 0; i < int'(ACC_SLOTS); i++) begin
      acc_d[i] = acc_clr ? '0 : acc_q[i];
    end
    if (accept && dec_we) begin
      acc_d[in_acc_sel] = dec_imm;
    end
  end

  always_comb begin
    out_valid_d  = out_valid_q;
    out_imm_d    = out_imm_q;
    out_err_d    = out_err_q;
    skid_valid_d = skid_valid_q;
    skid_imm_d   = skid_imm_q;
    skid_err_d   = skid_err_q;
    if (!out_valid_q || out_ready) begin
      if (skid_valid_q) begin
        out_valid_d  = 1'b1;
        out_imm_d    = skid_imm_q;
        out_err_d    = skid_err_q;
        skid_valid_d = accept;
        if (accept) begin
          skid_imm_d = dec_imm;
          skid_err_d = dec_err;
        end
      end else begin
        out_valid_d = accept;
        if (accept) begin
          out_imm_d = dec_imm;
          out_err_d = dec_err;
        end
      end
    end else if (accept) begin
      skid_valid_d = 1'b1;
      skid_imm_d   = dec_imm;
      skid_err_d   = dec_err;
    end
  end

  always_ff @(posedge CLK or negedge resetl) begin
    if (!resetl) begin
      for (int i = 0; i < int'(ACC_SLOTS); i++) begin
        acc_q[i] <= '0;
      end
      out_valid_q  <= 1'b0;
      out_imm_q    <= '0;
      out_err_q    <= 1'b0;
      skid_valid_q <= 1'b0;
      skid_imm_q   <= '0;
      skid_err_q   <= 1'b0;
    end else begin
      for (int i = 0; i < int'(ACC_SLOTS); i++) begin
        acc_q[i] <= acc_d[i];
      end
      out_valid_q  <= out_valid_d;
      out_imm_q    <= out_imm_d;
      out_err_q    <= out_err_d;
      skid_valid_q <= skid_valid_d;
      skid_imm_q   <= skid_imm_d;
      skid_err_q   <= skid_err_d;
    end
  end

endmodule

// File: tb/tb_imm_extend_pipe.sv
// Scoreboard bench for imm_extend_pipe: 64-bit and 32-bit instances against a behavioural model.
module tb_imm_extend_pipe;
  import imm_pkg::*;

  typedef struct packed {
    logic [63:0] imm;
    logic        err;
  } exp_t;

  logic CLK = 1'b0;
  logic resetl;
  always #5 CLK = ~CLK;

  // 64-bit instance
  logic        in_valid, in_ready, acc_clr, out_valid, out_ready, out_err;
  logic [25:0] in_imm;
  logic [3:0]  in_ctrl;
  logic [1:0]  in_acc_sel;
  logic [63:0] out_imm;

  // 32-bit instance
  logic        s_in_valid, s_in_ready, s_acc_clr, s_out_valid, s_out_ready, s_out_err;
  logic [25:0] s_in_imm;
  logic [3:0]  s_in_ctrl;
  logic [1:0]  s_in_acc_sel;
  logic [31:0] s_out_imm;

  imm_extend_pipe #(.DATA_W(64), .ACC_SLOTS(4)) u_dut64 (
    .CLK(CLK), .resetl(resetl), .in_valid(in_valid), .in_ready(in_ready), .in_imm(in_imm),
    .in_ctrl(in_ctrl), .in_acc_sel(in_acc_sel), .acc_clr(acc_clr), .out_valid(out_valid),
    .out_ready(out_ready), .out_imm(out_imm), .out_err(out_err)
  );

  imm_extend_pipe #(.DATA_W(32), .ACC_SLOTS(4)) u_dut32 (
    .CLK(CLK), .resetl(resetl), .in_valid(s_in_valid), .in_ready(s_in_ready),
    .in_imm(s_in_imm), .in_ctrl(s_in_ctrl), .in_acc_sel(s_in_acc_sel), .acc_clr(s_acc_clr),
    .out_valid(s_out_valid), .out_ready(s_out_ready), .out_imm(s_out_imm), .out_err(s_out_err)
  );

  int   n_cmp = 0;
  int   n_fail = 0;
  exp_t q64[$];
  exp_t q32[$];
  logic [63:0] m_acc [2][4];
  int   ready_mode = 0;  // 0: always ready, 1: random, 2: held low
  bit   stall_off = 1'b1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  function automatic logic [25:0] mov_imm(input logic [1:0] hw, input logic [15:0] v);
    return {3'b000, hw, v, 5'b00000};
  endfunction

  // Reference: formats computed from the field rules with plain arithmetic.
  function automatic void model(input int dw, input logic [3:0] ctrl, input logic [25:0] imm,
                                input logic [63:0] acc, output logic [63:0] res,
                                output logic err, output logic we);
    logic [63:0]        mask, place, old_hw;
    logic signed [63:0] sv;
    int                 sh;
    mask  = (dw == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << dw) - 64'd1);
    sh    = 16 * int'(imm[22:21]);
    place = 64'(imm[20:5]) << sh;
    err = 1'b0;
    we  = 1'b0;
    res = '0;
    case (ctrl)
      4'd0: begin sv = $signed(imm[20:12]); res = sv; end
      4'd1: res = 64'(imm[21:10]);
      4'd2: begin sv = $signed({imm[23:5], 2'b00}); res = sv; end
      4'd3: begin sv = $signed({imm, 2'b00}); res = sv; end
      4'd6: res = 64'(imm[21:10]) * (imm[22] ? 64'd4096 : 64'd1);
      4'd4, 4'd5, 4'd7: begin
        if (sh >= dw) begin
          err = 1'b1;
        end else begin
          we = 1'b1;
          if (ctrl == 4'd4) res = place;
          else if (ctrl == 4'd7) res = ~place;
          else begin
            old_hw = ((acc >> sh) & 64'hFFFF) << sh;
            res = acc - old_hw + place;
          end
        end
      end
      default: begin res = 64'(imm); err = 1'b1; end
    endcase
    res = res & mask;
  endfunction

  task automatic issue(input int inst, input logic [3:0] ctrl, input logic [25:0] imm,
                       input logic [1:0] sel, input logic clr, input bit use_exp,
                       input logic [63:0] exp_imm, input logic exp_err);
    logic [63:0] a, r;
    logic        e, we, rdy;
    int          waited;
    exp_t        x;
    waited = 0;
    @(negedge CLK);
    if (inst == 0) begin
      in_valid = 1'b1; in_ctrl = ctrl; in_imm = imm; in_acc_sel = sel; acc_clr = clr;
    end else begin
      s_in_valid = 1'b1; s_in_ctrl = ctrl; s_in_imm = imm; s_in_acc_sel = sel; s_acc_clr = clr;
    end
    #1;
    rdy = (inst == 0) ? in_ready : s_in_ready;
    while (!rdy) begin
      if (clr) for (int k = 0; k < 4; k++) m_acc[inst][k] = '0;
      if (waited > 200) begin
        n_cmp++;
        n_fail++;
        $display("FAIL accept_timeout: got in_ready=0 after %0d cycles want 1", waited);
        in_valid = 1'b0; acc_clr = 1'b0; s_in_valid = 1'b0; s_acc_clr = 1'b0;
        return;
      end
      @(negedge CLK);
      #1;
      waited++;
      rdy = (inst == 0) ? in_ready : s_in_ready;
    end
    a = clr ? 64'd0 : m_acc[inst][sel];
    model((inst == 0) ? 64 : 32, ctrl, imm, a, r, e, we);
    if (clr) for (int k = 0; k < 4; k++) m_acc[inst][k] = '0;
    if (we) m_acc[inst][sel] = r;
    x.imm = use_exp ? exp_imm : r;
    x.err = use_exp ? exp_err : e;
    if (inst == 0) q64.push_back(x);
    else q32.push_back(x);
    @(posedge CLK);
    #1;
    in_valid = 1'b0; acc_clr = 1'b0; s_in_valid = 1'b0; s_acc_clr = 1'b0;
  endtask

  initial begin
    out_ready = 1'b1;
    s_out_ready = 1'b1;
    forever begin
      @(negedge CLK);
      case (ready_mode)
        1: begin out_ready = 1'($urandom); s_out_ready = 1'($urandom); end
        2: begin out_ready = 1'b0; s_out_ready = 1'b0; end
        default: begin out_ready = 1'b1; s_out_ready = 1'b1; end
      endcase
    end
  end

  // Monitor for the 64-bit instance: pops on every transfer, checks hold while stalled.
  initial begin
    exp_t        e;
    logic        prev_stall;
    logic [63:0] prev_imm;
    logic        prev_err;
    prev_stall = 1'b0;
    forever begin
      @(negedge CLK);
      #2;
      if (!resetl || stall_off) begin
        prev_stall = 1'b0;
      end else begin
        if (prev_stall) begin
          n_cmp++;
          if (!out_valid || out_imm !== prev_imm || out_err !== prev_err) begin
            n_fail++;
            $display("FAIL hold64: got v=%b %h/%b want v=1 %h/%b", out_valid, out_imm, out_err,
                     prev_imm, prev_err);
          end
        end
        if (out_valid && out_ready) begin
          n_cmp++;
          if (q64.size() == 0) begin
            n_fail++;
            $display("FAIL out64_extra: got %h/%b want no output", out_imm, out_err);
          end else begin
            e = q64.pop_front();
            if (out_imm !== e.imm || out_err !== e.err) begin
              n_fail++;
              $display("FAIL out64: got %h/%b want %h/%b", out_imm, out_err, e.imm, e.err);
            end
          end
        end
        prev_stall = out_valid && !out_ready;
        prev_imm   = out_imm;
        prev_err   = out_err;
      end
    end
  end

  // Monitor for the 32-bit instance.
  initial begin
    exp_t e;
    forever begin
      @(negedge CLK);
      #2;
      if (resetl && !stall_off && s_out_valid && s_out_ready) begin
        n_cmp++;
        if (q32.size() == 0) begin
          n_fail++;
          $display("FAIL out32_extra: got %h/%b want no output", s_out_imm, s_out_err);
        end else begin
          e = q32.pop_front();
          if ({32'd0, s_out_imm} !== e.imm || s_out_err !== e.err) begin
            n_fail++;
            $display("FAIL out32: got %h/%b want %h/%b", s_out_imm, s_out_err, e.imm, e.err);
          end
        end
      end
    end
  end

  initial begin
    int          inst, w;
    logic [3:0]  c;
    resetl = 1'b0;
    in_valid = 1'b0; in_imm = '0; in_ctrl = '0; in_acc_sel = '0; acc_clr = 1'b0;
    s_in_valid = 1'b0; s_in_imm = '0; s_in_ctrl = '0; s_in_acc_sel = '0; s_acc_clr = 1'b0;
    for (int i = 0; i < 2; i++) for (int k = 0; k < 4; k++) m_acc[i][k] = '0;
    #1;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_out_imm", out_imm, 64'd0);
    check("rst_out_err", 64'(out_err), 64'd0);
    check("rst32_out_valid", 64'(s_out_valid), 64'd0);
    check("rst32_in_ready", 64'(s_in_ready), 64'd1);
    repeat (2) @(negedge CLK);
    check("rst_held_in_ready", 64'(in_ready), 64'd1);
    #2;
    resetl = 1'b1;
    stall_off = 1'b0;

    issue(0, IMM_CTRL_ADDI, {4'b0, 12'hFFF, 10'b0}, 2'd0, 1'b0, 1, 64'h0000_0000_0000_0FFF, 1'b0);
    check("latency_out_valid", 64'(out_valid), 64'd1);
    issue(0, IMM_CTRL_CBZ, {2'b0, 19'h40000, 5'b0}, 2'd0, 1'b0, 1, 64'hFFFF_FFFF_FFF0_0000, 1'b0);
    issue(0, IMM_CTRL_B, 26'h3FF_FFFF, 2'd0, 1'b0, 1, 64'hFFFF_FFFF_FFFF_FFFC, 1'b0);
    issue(0, IMM_CTRL_MOVZ, mov_imm(2'd1, 16'h1234), 2'd2, 1'b0, 1, 64'h0000_0000_1234_0000, 1'b0);
    issue(0, IMM_CTRL_MOVK, mov_imm(2'd0, 16'hABCD), 2'd2, 1'b0, 1, 64'h0000_0000_1234_ABCD, 1'b0);
    issue(0, IMM_CTRL_MOVN, mov_imm(2'd0, 16'h0000), 2'd1, 1'b0, 1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
    issue(0, IMM_CTRL_MOVK, mov_imm(2'd2, 16'h0000), 2'd2, 1'b0, 1, 64'h0000_0000_1234_ABCD, 1'b0);

    // Stall the consumer: two accepts fill output and skid, the third waits.
    repeat (3) @(negedge CLK);
    @(posedge CLK);
    ready_mode = 2;
    issue(0, IMM_CTRL_ADDI, {4'b0, 12'h111, 10'b0}, 2'd0, 1'b0, 1, 64'h111, 1'b0);
    issue(0, IMM_CTRL_ADDI, {4'b0, 12'h222, 10'b0}, 2'd0, 1'b0, 1, 64'h222, 1'b0);
    check("skid_full_in_ready", 64'(in_ready), 64'd0);
    fork
      issue(0, IMM_CTRL_ADDI, {4'b0, 12'h333, 10'b0}, 2'd0, 1'b0, 1, 64'h333, 1'b0);
      begin
        repeat (2) @(posedge CLK);
        ready_mode = 0;
      end
    join
    repeat (4) @(negedge CLK);

    // 32-bit instance: out-of-range halfword must not disturb the slot.
    issue(1, IMM_CTRL_MOVZ, mov_imm(2'd2, 16'h1234), 2'd3, 1'b0, 1, 64'd0, 1'b1);
    issue(1, IMM_CTRL_MOVK, mov_imm(2'd0, 16'h0005), 2'd3, 1'b0, 1, 64'h0000_0005, 1'b0);
    issue(1, 4'd9, 26'h2AB_CDEF, 2'd0, 1'b0, 1, 64'h02AB_CDEF, 1'b1);
    repeat (4) @(negedge CLK);

    // Asynchronous reset with output and skid both occupied.
    @(posedge CLK);
    ready_mode = 2;
    issue(0, IMM_CTRL_MOVZ, mov_imm(2'd0, 16'h00AA), 2'd0, 1'b0, 1, 64'hAA, 1'b0);
    issue(0, IMM_CTRL_MOVZ, mov_imm(2'd1, 16'h00BB), 2'd0, 1'b0, 1, 64'hBB_0000, 1'b0);
    check("pre_rst_in_ready", 64'(in_ready), 64'd0);
    #3;
    stall_off = 1'b1;
    resetl = 1'b0;
    #1;
    check("async_rst_out_valid", 64'(out_valid), 64'd0);
    check("async_rst_in_ready", 64'(in_ready), 64'd1);
    check("async_rst_out_imm", out_imm, 64'd0);
    check("async_rst_out_err", 64'(out_err), 64'd0);
    q64.delete();
    q32.delete();
    for (int i = 0; i < 2; i++) for (int k = 0; k < 4; k++) m_acc[i][k] = '0;
    ready_mode = 0;
    repeat (2) @(negedge CLK);
    #3;
    resetl = 1'b1;
    stall_off = 1'b0;
    issue(0, IMM_CTRL_MOVK, mov_imm(2'd0, 16'h0007), 2'd0, 1'b0, 1, 64'h7, 1'b0);

    // Randomised traffic with a randomly stalling consumer.
    ready_mode = 1;
    for (int n = 0; n < 400; n++) begin
      inst = ($urandom_range(0, 3) == 0) ? 1 : 0;
      if ($urandom_range(0, 7) == 0) c = 4'($urandom_range(8, 15));
      else c = 4'($urandom_range(0, 7));
      issue(inst, c, 26'($urandom), 2'($urandom), 1'($urandom_range(0, 15) == 0), 0, 64'd0,
            1'b0);
      if ($urandom_range(0, 3) == 0) @(negedge CLK);
    end

    ready_mode = 0;
    w = 0;
    while ((q64.size() != 0 || q32.size() != 0) && w < 100) begin
      @(negedge CLK);
      w++;
    end
    check("drain_pending", 64'(q64.size() + q32.size()), 64'd0);
    repeat (2) @(negedge CLK);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/imm_extend_pipe.md
Name: imm_extend_pipe

Overview:
- Parametrised, pipelined successor to the datapath sign extender.
- Decodes the instruction's low 26 bits into a DATA_W-bit immediate for D, I, CB, B and wide-move formats.
- Adds MOVK/MOVN support through per-slot constant accumulators.
- Sits between fetch/decode and the ALU B-mux behind a valid/ready handshake, so multi-cycle datapath variants can stall it.

Parameters:
- DATA_W, 64, output width; multiple of 16, minimum 32.
- ACC_SLOTS, 4, number of wide-move accumulators; power of 2, minimum 2.
- SEL_W, $clog2(ACC_SLOTS), derived accumulator select width; not overridable.

Ports:
- CLK  in  1  clock, rising edge.
- resetl  in  1  asynchronous active-low reset.
- in_valid  in  1  request valid.
- in_ready  out  1  request accepted when in_valid & in_ready.
- in_imm  in  26  instruction bits [25:0].
- in_ctrl  in  4  format select (encodings below).
- in_acc_sel  in  SEL_W  accumulator slot used by MOVZ/MOVK/MOVN.
- acc_clr  in  1  clears all accumulators.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer ready.
- out_imm  out  DATA_W  extended immediate.
- out_err  out  1  illegal ctrl or halfword shift out of range.

Behaviour:
- Formats by in_ctrl; sext = sign-extend, zext = zero-extend to DATA_W:
  - 0 LDUR/STUR: sext [20:12].
  - 1 ADD/SUB: zext [21:10].
  - 2 CBZ: sext {[23:5],2'b00}.
  - 3 B: sext {[25:0],2'b00}.
  - 4 MOVZ: zext [20:5] << (16*hw).
  - 5 MOVK: acc[sel] with halfword hw replaced by [20:5].
  - 6 ADD/SUB shifted: zext [21:10] << (12*[22]).
  - 7 MOVN: ~(zext [20:5] << (16*hw)).
  - hw = in_imm[22:21].
- in_ctrl 8-15: out_imm = zext in_imm, out_err=1, no accumulator write.
- hw*16 >= DATA_W (e.g. DATA_W=32 with hw>=2) on ctrl 4/5/7: out_imm=0, out_err=1, no accumulator write.
- Accumulators:
  - Compute happens at accept time.
  - Legal MOVZ/MOVK/MOVN write their result into acc[in_acc_sel] on the accept edge.
  - Back-to-back MOVK to the same slot therefore chains with no hazard.
  - Other formats never touch accumulators.
- acc_clr:
  - Zeroes all slots on the clock edge.
  - If it coincides with an accept, the accepted op sees all-zero accumulators, and its write-back lands after the clear (so the written slot holds the new result).
- Pipeline:
  - Output register plus one skid register.
  - Latency: accept on edge t → out_valid=1 after edge t; out_imm/out_err stable while out_valid & !out_ready.
  - in_ready = !skid_valid, driven from a register with no combinational path from out_ready.
  - Full throughput of 1/cycle while out_ready=1.
- Skid rules:
  - Accept while the output register is full and not draining → entry goes to skid; in_ready drops next cycle.
  - Output register drains with skid_valid=1 → skid moves to output, and skid takes any simultaneous accept.
  - Output order always equals accept order; no drop, no duplicate.
- Reset (asynchronous, any time including mid-transfer):
  - out_valid=0, out_imm=0, out_err=0, skid empty, all accumulators 0.
  - in_ready=1 while held and after release.
  - In-flight entries are discarded.

Decomposition:
- Shared package (imm_pkg) holds:
  - IMM_CTRL_* localparams (4-bit encodings 0-7).
  - Field position constants (D/I/CB/B/MOV bit ranges).
  - Function hw_shift_legal(hw, DATA_W).
- Natural sub-module: imm_decode, purely combinational (in_imm, in_ctrl, acc_rd → imm, err, acc_we).
- imm_extend_pipe owns the accumulators, output register and skid.

Test Plan:
- ctrl=1, in_imm[21:10]=0xFFF, out_ready=1 → next cycle out_valid=1, out_imm=0x0000_0000_0000_0FFF, out_err=0.
- ctrl=2, in_imm[23:5]=0x40000 → out_imm=0xFFFF_FFFF_FFF0_0000; ctrl=3, in_imm=0x3FFFFFF → out_imm=0xFFFF_FFFF_FFFF_FFFC.
- Back-to-back, sel=2:
  - MOVZ hw=1 imm16=0x1234 → 0x0000_0000_1234_0000.
  - MOVK hw=0 imm16=0xABCD → 0x0000_0000_1234_ABCD.
  - MOVN hw=0 imm16=0 on sel=1 → 0xFFFF_FFFF_FFFF_FFFF, slot 2 unchanged.
- out_ready=0, 3 requests offered on consecutive cycles:
  - 2 accepted, then in_ready=0.
  - out_ready=1 → outputs emerge in order on consecutive cycles, third then accepted.
- DATA_W=32 instance, MOVZ hw=2 → out_imm=0, out_err=1; following MOVK hw=0 imm16=0x5 → 0x0000_0005 (slot still 0); ctrl=9 → out_err=1.
- resetl=0 asynchronously while out_valid=1 and skid full → out_valid=0, in_ready=1 immediately; after release, a MOVK hw=0 imm16=0x7 → 0x0000_0000_0000_0007 (accumulator cleared).
